qadd_pipe: RTL and testbench

//  Pipelined, parametrised sign-magnitude fixed-point adder/subtractor/accumulator.

---
 rtl/qadd_pipe_pkg.sv | 16 +
 rtl/qadd_pipe_if.sv | 26 ++
 rtl/qadd_pipe_core.sv | 43 ++++
 rtl/qadd_pipe.sv | 119 +++++++++++
 tb/tb_qadd_pipe.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/qadd_pipe_pkg.sv
// Shared definitions for the sign-magnitude add/sub/accumulate pipeline.
package qadd_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Ops whose result is written back into the running accumulator.
  function automatic logic op_writes_acc(input op_e op);
    return (op == OP_ACC) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/qadd_pipe_if.sv
// Operand/result stream bundle for qadd_pipe: input handshake plus output handshake.
interface qadd_pipe_if #(
  parameter int N = 32
);
  import qadd_pipe_pkg::*;

  logic         in_valid;
  logic         in_ready;
  op_e          op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         sat;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, c, sat
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, c, sat
  );
endinterface

// File: rtl/qadd_pipe_core.sv
// Combinational sign-magnitude adder with optional magnitude saturation.
// Operands are expected without -0; the result never carries -0.
module qadd_core #(
  parameter int N   = 32,
  parameter bit SAT = 1'b1
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  output logic [N-1:0] c_o,
  output logic         sat_o
);
  localparam int M = N - 1;

  logic [M-1:0] mx;
  logic [M-1:0] my;
  logic [M:0]   sum;
  logic [M-1:0] mag;
  logic         sign;

  // Same signs add magnitudes (carry is the overflow); opposite signs subtract smaller from larger.
  always_comb begin
    mx    = x_i[M-1:0];
    my    = y_i[M-1:0];
    sum   = {1'b0, mx} + {1'b0, my};
    sat_o = 1'b0;
    mag   = '0;
    sign  = x_i[N-1];
    if (x_i[N-1] == y_i[N-1]) begin
      if (sum[M]) begin
        sat_o = 1'b1;
        mag   = SAT ? {M{1'b1}} : sum[M-1:0];
      end else begin
        mag = sum[M-1:0];
      end
    end else if (mx >= my) begin
      mag = mx - my;
    end else begin
      mag  = my - mx;
      sign = y_i[N-1];
    end
    c_o = {sign & (mag != '0), mag};
  end
endmodule

// File: rtl/qadd_pipe.sv
// Two-stage pipelined sign-magnitude add/sub/accumulate with valid/ready on both sides.
// S1 registers normalised operands and op; S2 combines them (or the accumulator) and
// registers the result, which doubles as the output register.
module qadd_pipe
  import qadd_pipe_pkg::*;
#(
  parameter int Q   = 15,
  parameter int N   = 32,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  qadd_pipe_if.slave   bus
);

  if ((N < 4) || (Q > N - 2)) begin : g_param_chk
    $error("qadd_pipe: requires N >= 4 and Q <= N-2");
  end

  // Clear the magnitude-zero case to +0 so downstream logic never sees -0.
  function automatic logic [N-1:0] norm_zero(input logic [N-1:0] v);
    return (v[N-2:0] == '0) ? '0 : v;
  endfunction

  logic         advance;
  logic         in_ready;
  logic         accept;

  logic         s1_valid_q;
  op_e          s1_op_q;
  logic [N-1:0] s1_a_q;
  logic [N-1:0] s1_b_q;
  logic [N-1:0] s1_a_d;
  logic [N-1:0] s1_b_d;

  logic [N-1:0] y_s2;
  logic [N-1:0] core_c;
  logic         core_sat;

  logic         out_valid_q;
  logic [N-1:0] c_q;
  logic         sat_q;
  logic [N-1:0] acc_q;

  // The whole pipe moves when the output register is empty or being drained.
  assign advance  = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || advance;
  assign accept   = bus.in_valid && in_ready;

  // SUB is turned into ADD by flipping b's sign before registering.
  always_comb begin
    s1_a_d = norm_zero(bus.a);
    s1_b_d = norm_zero((bus.op == OP_SUB) ? {~bus.b[N-1], bus.b[N-2:0]} : bus.b);
  end

  // ---- Stage 1: operand/op capture ----
  // S1 occupancy tracks accepted inputs and is released whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= bus.in_valid;
    end
  end

  // S1 operand registers load only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_op_q <= bus.op;
    end
  end

  // ---- Stage 2: combine and register result ----
  // Second operand: b for ADD/SUB, the accumulator for ACC, +0 for LOAD.
  always_comb begin
    unique case (s1_op_q)
      OP_ACC:  y_s2 = acc_q;
      OP_LOAD: y_s2 = '0;
      default: y_s2 = s1_b_q;
    endcase
  end

  qadd_core #(
    .N   (N),
    .SAT (SAT)
  ) u_core (
    .x_i   (s1_a_q),
    .y_i   (y_s2),
    .c_o   (core_c),
    .sat_o (core_sat)
  );

  // Result/accumulator capture; acc is written exactly once per ACC/LOAD, when it enters the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
    end else if (advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        c_q   <= core_c;
        sat_q <= core_sat;
        if (op_writes_acc(s1_op_q)) begin
          acc_q <= core_c;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_qadd_pipe.sv
// Scoreboard bench for qadd_pipe: expected results are queued at input acceptance and
// compared in order as the DUT hands results out.
module tb_qadd_pipe;
  import qadd_pipe_pkg::*;

  localparam int N = 32;

  typedef struct packed {
    logic [N-1:0] c;
    logic         sat;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  qadd_pipe_if #(.N(N)) bus ();
  qadd_pipe_if #(.N(N)) busw ();

  qadd_pipe #(.Q(15), .N(N), .SAT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  qadd_pipe #(.Q(15), .N(N), .SAT(1'b0)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busw.slave)
  );

  int           checks   = 0;
  int           failures = 0;
  res_t         exp_q[$];
  logic [N-1:0] m_acc;
  bit           mon_en    = 1'b0;
  bit           rnd_ready = 1'b0;
  bit           rdy_force = 1'b1;
  bit           rnd_bit   = 1'b1;
  bit           stall_hold = 1'b0;
  logic [N-1:0] held_c;
  res_t         mon_r;

  assign bus.out_ready = rnd_ready ? rnd_bit : rdy_force;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Value-domain reference: convert to signed integers, add, then re-encode.
  function automatic res_t model_add(input logic [N-1:0] x, input logic [N-1:0] y, input bit sat_mode);
    res_t         r;
    longint       sx, sy, s, mag;
    longint       lim;
    logic [N-2:0] m;
    lim = longint'(1) << (N - 1);
    sx  = x[N-1] ? -longint'(x[N-2:0]) : longint'(x[N-2:0]);
    sy  = y[N-1] ? -longint'(y[N-2:0]) : longint'(y[N-2:0]);
    s   = sx + sy;
    mag = (s < 0) ? -s : s;
    r.sat = 1'b0;
    if (mag >= lim) begin
      r.sat = 1'b1;
      mag   = sat_mode ? lim - 1 : mag - lim;
    end
    m   = mag[N-2:0];
    r.c = {(s < 0) && (m != '0), m};
    return r;
  endfunction

  function automatic res_t model_op(input op_e op, input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic [N-1:0] acc);
    case (op)
      OP_ADD:  return model_add(a, b, 1'b1);
      OP_SUB:  return model_add(a, {~b[N-1], b[N-2:0]}, 1'b1);
      OP_ACC:  return model_add(a, acc, 1'b1);
      default: return model_add(a, '0, 1'b1);
    endcase
  endfunction

  // Present one op from posedge+1; on acceptance queue its expected result.
  task automatic send(input op_e op, input logic [N-1:0] a, input logic [N-1:0] b);
    res_t r;
    int   n  = 0;
    bit   ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
      n++;
    end
    check("accept", N'(ok), N'(1));
    if (ok) begin
      r = model_op(op, a, b, m_acc);
      if (op == OP_ACC || op == OP_LOAD) m_acc = r.c;
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", N'(exp_q.size()), N'(0));
    @(posedge clk);
    #1;
  endtask

  // One op through the wrapping (SAT=0) instance, checked directly.
  task automatic wsend(input logic [N-1:0] a, input logic [N-1:0] b);
    res_t r;
    int   n = 0;
    r = model_add(a, b, 1'b0);
    busw.in_valid = 1'b1;
    busw.op       = OP_ADD;
    busw.a        = a;
    busw.b        = b;
    @(posedge clk);
    #1;
    busw.in_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!busw.out_valid && n < 10);
    check("wrap_vld", N'(busw.out_valid), N'(1));
    check("wrap_c", busw.c, r.c);
    check("wrap_sat", N'(busw.sat), N'(r.sat));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Output side: pop on handshake, and verify held values across stalled cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_hold) begin
        check("stall_c", bus.c, held_c);
        check("stall_vld", N'(bus.out_valid), N'(1));
      end
      stall_hold = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", N'(exp_q.size() != 0), N'(1));
        if (exp_q.size() != 0) begin
          mon_r = exp_q.pop_front();
          check("c", bus.c, mon_r.c);
          check("sat", N'(bus.sat), N'(mon_r.sat));
        end
      end else if (bus.out_valid) begin
        stall_hold = 1'b1;
        held_c     = bus.c;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb;
    op_e          rop;

    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    busw.in_valid = 1'b0;
    busw.op       = OP_ADD;
    busw.a        = '0;
    busw.b        = '0;
    busw.out_ready = 1'b1;
    m_acc = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_vld", N'(bus.out_valid), N'(0));
    check("rst_c", bus.c, '0);
    check("rst_sat", N'(bus.sat), N'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_rdy", N'(bus.in_ready), N'(1));
    mon_en = 1'b1;

    // Basic add and two-cycle latency
    send(OP_ADD, 32'h0000C000, 32'h80004000);
    @(negedge clk);
    check("lat_c1", N'(bus.out_valid), N'(0));
    @(negedge clk);
    check("lat_c2", N'(bus.out_valid), N'(1));
    @(posedge clk);
    #1;
    drain();

    // Zero results never negative
    send(OP_SUB, 32'h00004000, 32'h00004000);
    send(OP_ADD, 32'h80000000, 32'h00000000);
    drain();

    // Overflow, saturating and wrapping
    send(OP_ADD, 32'h7FFFFFFF, 32'h00000001);
    send(OP_ADD, 32'hFFFFFFFF, 32'h80000001);
    drain();
    wsend(32'h7FFFFFFF, 32'h00000001);
    wsend(32'hFFFFFFFF, 32'h80000001);

    // Accumulator chain, then read acc back via ACC +0
    send(OP_LOAD, 32'h00008000, 32'h0);
    send(OP_ACC, 32'h80004000, 32'h0);
    send(OP_ACC, 32'h80004000, 32'h0);
    send(OP_ACC, 32'h80004000, 32'h0);
    send(OP_ACC, 32'h00000000, 32'h0);
    drain();

    // Random stream with backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rop = op_e'($urandom_range(0, 3));
      ra  = (i % 5 == 3) ? 32'h80000000 : $urandom;
      rb  = (i % 7 == 2) ? 32'h80000000 : $urandom;
      if (i % 3 == 0) ra[30:20] = '0;
      send(rop, ra, rb);
    end
    rnd_ready = 1'b0;
    rdy_force = 1'b1;
    drain();

    // Reset with two ops in flight
    rdy_force = 1'b0;
    send(OP_ADD, 32'h00000001, 32'h00000002);
    send(OP_ACC, 32'h00000003, 32'h00000004);
    mon_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_vld", N'(bus.out_valid), N'(0));
    check("rst2_c", bus.c, '0);
    check("rst2_rdy", N'(bus.in_ready), N'(1));
    exp_q.delete();
    m_acc      = '0;
    stall_hold = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rdy_force = 1'b1;
    mon_en    = 1'b1;
    send(OP_ACC, 32'h00002000, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
